challengeqsys_pixelbuf_arbiter: RTL

Two-requester arbiter sharing the single-port 32768 x 8 pixel test RAM between the Nios II host (Avalon-MM slave with waitrequest and readdatavalid) and the video scan-out engine (read-only request/grant stream). It sits between both masters and the RAM's s1 port, so one arbiter owns all accesses. It also tracks read-data ownership across the RAM's one-cycle read latency and counts arbitration conflicts.

---
 rtl/challengeqsys_pixelbuf_pkg.sv | 20 ++
 rtl/challengeqsys_rr_arb2.sv | 52 +++++
 rtl/challengeqsys_pixelbuf_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/challengeqsys_pixelbuf_pkg.sv
// Shared types and constants for the pixel test RAM arbiter.
//   PIX_ADDR_W / PIX_DATA_W : geometry of the 32768 x 8 pixel test RAM
//   owner_t                 : which master an access belongs to
//   rd_tag_t                : ownership of the read currently in the RAM pipeline
package challengeqsys_pixelbuf_pkg;

  localparam int PIX_ADDR_W = 15;
  localparam int PIX_DATA_W = 8;

  typedef enum logic {
    OWN_HOST   = 1'b0,
    OWN_STREAM = 1'b1
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } rd_tag_t;

endpackage

// File: rtl/challengeqsys_rr_arb2.sv
// Two-input round-robin arbiter.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   i_req_host      : host request
//   i_req_stream    : scan-out request
//   o_grant_host    : host granted this cycle (combinational)
//   o_grant_stream  : scan-out granted this cycle (combinational)
// A sole requester always wins; on a conflict the side that did not win
// last time gets the slot. Both grants are held low while reset is high.
module challengeqsys_rr_arb2
  import challengeqsys_pixelbuf_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_req_host,
  input  logic i_req_stream,
  output logic o_grant_host,
  output logic o_grant_stream
);

  owner_t r_last_owner;
  logic   w_host_turn;

  assign w_host_turn = (r_last_owner == OWN_STREAM);

  always_comb begin
    o_grant_host   = 1'b0;
    o_grant_stream = 1'b0;
    if (!reset) begin
      if (i_req_host && i_req_stream) begin
        o_grant_host   = w_host_turn;
        o_grant_stream = ~w_host_turn;
      end else begin
        o_grant_host   = i_req_host;
        o_grant_stream = i_req_stream;
      end
    end
  end

  // Only an actual grant moves the pointer; a requester that gives up while
  // stalled leaves it untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_owner <= OWN_STREAM;
    end else if (o_grant_host) begin
      r_last_owner <= OWN_HOST;
    end else if (o_grant_stream) begin
      r_last_owner <= OWN_STREAM;
    end
  end

endmodule

// File: rtl/challengeqsys_pixelbuf_arbiter.sv
// Arbiter sharing the single-port pixel test RAM between the Nios II host
// (Avalon-MM slave) and the video scan-out read stream.
// Ports:
//   clk, reset                       : clock, synchronous active-high reset
//   h_*                              : host Avalon-MM slave (waitrequest, readdatavalid)
//   s_req/s_address/s_grant          : scan-out request/grant
//   s_rdata/s_rvalid                 : scan-out read return
//   ram_*                            : RAM s1 port (one-cycle read latency)
//   clear_stats                      : synchronous clear of conflict_count
//   conflict_count                   : saturating count of cycles with both requesting
module challengeqsys_pixelbuf_arbiter
  import challengeqsys_pixelbuf_pkg::*;
#(
  parameter int ADDR_W = PIX_ADDR_W,
  parameter int DATA_W = PIX_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] h_address,
  input  logic              h_chipselect,
  input  logic              h_read,
  input  logic              h_write,
  input  logic [DATA_W-1:0] h_writedata,
  output logic              h_waitrequest,
  output logic [DATA_W-1:0] h_readdata,
  output logic              h_readdatavalid,
  input  logic              s_req,
  input  logic [ADDR_W-1:0] s_address,
  output logic              s_grant,
  output logic [DATA_W-1:0] s_rdata,
  output logic              s_rvalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata,
  input  logic              clear_stats,
  output logic [CNT_W-1:0]  conflict_count
);

  logic             w_hreq;
  logic             w_sreq;
  logic             w_grant_host;
  logic             w_grant_stream;
  rd_tag_t          r_tag;
  logic [CNT_W-1:0] r_conflict_count;

  // Read and write together count as a write.
  assign w_hreq = h_chipselect & (h_read | h_write);
  assign w_sreq = s_req;

  challengeqsys_rr_arb2 u_arb (
    .clk            (clk),
    .reset          (reset),
    .i_req_host     (w_hreq),
    .i_req_stream   (w_sreq),
    .o_grant_host   (w_grant_host),
    .o_grant_stream (w_grant_stream)
  );

  assign h_waitrequest  = w_hreq & ~w_grant_host;
  assign s_grant        = w_sreq & w_grant_stream;

  assign ram_chipselect = w_grant_host | w_grant_stream;
  assign ram_address    = w_grant_host ? h_address : s_address;
  assign ram_write      = w_grant_host & h_write;
  assign ram_writedata  = h_writedata;
  assign ram_clken      = 1'b1;

  assign h_readdata     = ram_readdata;
  assign s_rdata        = ram_readdata;

  // The tag for a read granted just before reset is still set during the
  // reset cycle; masking with reset keeps that read from being reported.
  assign h_readdatavalid = ~reset & r_tag.valid & (r_tag.owner == OWN_HOST);
  assign s_rvalid        = ~reset & r_tag.valid & (r_tag.owner == OWN_STREAM);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag <= '{valid: 1'b0, owner: OWN_STREAM};
    end else if (w_grant_host) begin
      r_tag <= '{valid: ~h_write, owner: OWN_HOST};
    end else if (w_grant_stream) begin
      r_tag <= '{valid: 1'b1, owner: OWN_STREAM};
    end else begin
      r_tag.valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear_stats) begin
      r_conflict_count <= '0;
    end else if (w_hreq && w_sreq && (r_conflict_count != {CNT_W{1'b1}})) begin
      r_conflict_count <= r_conflict_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign conflict_count = r_conflict_count;

endmodule
